wshb_arbiter: RTL and testbench

WSHB_ARBITER -- requirements
Module: wshb_arbiter

---
 rtl/wshb_arbiter_pkg.sv | 40 ++++
 rtl/wshb_if.sv | 29 ++
 rtl/wshb_arbiter.sv | 115 +++++++++++
 tb/tb_wshb_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wshb_arbiter_pkg.sv
// rtl/wshb_arbiter_pkg.sv - shared types and grant decision for the two-master Wishbone arbiter
package wshb_arbiter_pkg;

  // Arbiter states: no owner, master 0 owns the bus, master 1 owns the bus.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  // Last-served value after reset. Marking master 1 as served last means
  // master 0 wins the first simultaneous request.
  localparam logic LAST_RESET = 1'b1;

  // Grant decision taken in IDLE. Only cyc counts as a request, so a stray
  // stb with cyc low is ignored. With both masters requesting, fixed
  // priority always picks master 0; otherwise the master not served last wins.
  function automatic arb_state_e pick_grant(
    input logic cyc0,
    input logic cyc1,
    input logic last,
    input logic fixed
  );
    arb_state_e nxt;
    nxt = IDLE;
    if (cyc0 && !cyc1) begin
      nxt = GNT0;
    end else if (!cyc0 && cyc1) begin
      nxt = GNT1;
    end else if (cyc0 && cyc1) begin
      if (fixed || last) begin
        nxt = GNT0;
      end else begin
        nxt = GNT1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/wshb_if.sv
// rtl/wshb_if.sv - 32-bit Wishbone B4 bus bundle with master and slave views
interface wshb_if;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        ack;
  logic        err;
  logic        rty;
  logic [2:0]  cti;
  logic [1:0]  bte;

  // Seen from the side that initiates transfers.
  modport master (
    output cyc, stb, we, sel, adr, dat_ms, cti, bte,
    input  dat_sm, ack, err, rty
  );

  // Seen from the side that answers transfers.
  modport slave (
    input  cyc, stb, we, sel, adr, dat_ms, cti, bte,
    output dat_sm, ack, err, rty
  );

endinterface

// File: rtl/wshb_arbiter.sv
// rtl/wshb_arbiter.sv - two-master Wishbone arbiter with a guard cycle between grants
module wshb_arbiter
  import wshb_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic   clk,
  input  logic   rst,
  wshb_if.slave  wb_m0,
  wshb_if.slave  wb_m1,
  wshb_if.master wb_s
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       fixed_prio;

  assign fixed_prio = (FIXED_PRIO != 0);

  // State and last-served registers; reset drops any grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= LAST_RESET;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next state: grants start only from IDLE and are held until the owner
  // drops cyc, so a handoff always passes through one IDLE guard cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        state_d = pick_grant(wb_m0.cyc, wb_m1.cyc, last_q, fixed_prio);
        if (state_d == GNT0) begin
          last_d = 1'b0;
        end else if (state_d == GNT1) begin
          last_d = 1'b1;
        end
      end
      GNT0: begin
        if (!wb_m0.cyc) begin
          state_d = IDLE;
        end
      end
      GNT1: begin
        if (!wb_m1.cyc) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Routing mux: the owner's request goes straight to the slave and the
  // slave's response goes only to the owner; in IDLE everything is quiet,
  // which also swallows a stale ack left over from an aborted transfer.
  always_comb begin
    wb_s.cyc    = 1'b0;
    wb_s.stb    = 1'b0;
    wb_s.we     = 1'b0;
    wb_s.sel    = 4'h0;
    wb_s.adr    = 32'h0;
    wb_s.dat_ms = 32'h0;
    wb_s.cti    = 3'h0;
    wb_s.bte    = 2'h0;
    wb_m0.ack   = 1'b0;
    wb_m0.err   = 1'b0;
    wb_m0.rty   = 1'b0;
    wb_m1.ack   = 1'b0;
    wb_m1.err   = 1'b0;
    wb_m1.rty   = 1'b0;
    case (state_q)
      GNT0: begin
        wb_s.cyc    = wb_m0.cyc;
        wb_s.stb    = wb_m0.stb;
        wb_s.we     = wb_m0.we;
        wb_s.sel    = wb_m0.sel;
        wb_s.adr    = wb_m0.adr;
        wb_s.dat_ms = wb_m0.dat_ms;
        wb_s.cti    = wb_m0.cti;
        wb_s.bte    = wb_m0.bte;
        wb_m0.ack   = wb_s.ack;
        wb_m0.err   = wb_s.err;
        wb_m0.rty   = wb_s.rty;
      end
      GNT1: begin
        wb_s.cyc    = wb_m1.cyc;
        wb_s.stb    = wb_m1.stb;
        wb_s.we     = wb_m1.we;
        wb_s.sel    = wb_m1.sel;
        wb_s.adr    = wb_m1.adr;
        wb_s.dat_ms = wb_m1.dat_ms;
        wb_s.cti    = wb_m1.cti;
        wb_s.bte    = wb_m1.bte;
        wb_m1.ack   = wb_s.ack;
        wb_m1.err   = wb_s.err;
        wb_m1.rty   = wb_s.rty;
      end
      default: begin
      end
    endcase
  end

  // Read data is broadcast; only the owner gets an ack to qualify it.
  assign wb_m0.dat_sm = wb_s.dat_sm;
  assign wb_m1.dat_sm = wb_s.dat_sm;

endmodule

// File: tb/tb_wshb_arbiter.sv
// tb/tb_wshb_arbiter.sv - self-checking bench for wshb_arbiter, round-robin and fixed-priority builds
module tb_wshb_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Shared master stimulus, fed to both arbiter builds
  logic        m_cyc  [2];
  logic        m_stb  [2];
  logic        m_we   [2];
  logic [3:0]  m_sel  [2];
  logic [31:0] m_adr  [2];
  logic [31:0] m_dat  [2];
  logic        m_ack  [2];
  logic [31:0] m_rdat [2];

  wshb_if m0a ();
  wshb_if m1a ();
  wshb_if sa ();
  wshb_if m0b ();
  wshb_if m1b ();
  wshb_if sb ();

  wshb_arbiter #(.FIXED_PRIO(0)) dut_rr (
    .clk   (clk),
    .rst   (rst),
    .wb_m0 (m0a),
    .wb_m1 (m1a),
    .wb_s  (sa)
  );

  wshb_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk   (clk),
    .rst   (rst),
    .wb_m0 (m0b),
    .wb_m1 (m1b),
    .wb_s  (sb)
  );

  assign m0a.cyc = m_cyc[0];  assign m1a.cyc = m_cyc[1];
  assign m0a.stb = m_stb[0];  assign m1a.stb = m_stb[1];
  assign m0a.we  = m_we[0];   assign m1a.we  = m_we[1];
  assign m0a.sel = m_sel[0];  assign m1a.sel = m_sel[1];
  assign m0a.adr = m_adr[0];  assign m1a.adr = m_adr[1];
  assign m0a.dat_ms = m_dat[0]; assign m1a.dat_ms = m_dat[1];
  assign m0a.cti = 3'h0; assign m1a.cti = 3'h0;
  assign m0a.bte = 2'h0; assign m1a.bte = 2'h0;

  assign m0b.cyc = m_cyc[0];  assign m1b.cyc = m_cyc[1];
  assign m0b.stb = m_stb[0];  assign m1b.stb = m_stb[1];
  assign m0b.we  = m_we[0];   assign m1b.we  = m_we[1];
  assign m0b.sel = m_sel[0];  assign m1b.sel = m_sel[1];
  assign m0b.adr = m_adr[0];  assign m1b.adr = m_adr[1];
  assign m0b.dat_ms = m_dat[0]; assign m1b.dat_ms = m_dat[1];
  assign m0b.cti = 3'h0; assign m1b.cti = 3'h0;
  assign m0b.bte = 2'h0; assign m1b.bte = 2'h0;

  assign m_ack[0]  = m0a.ack;
  assign m_ack[1]  = m1a.ack;
  assign m_rdat[0] = m0a.dat_sm;
  assign m_rdat[1] = m1a.dat_sm;

  // Block RAM slave, mem_adr_width = 11 (word addressed), one-cycle ack
  logic [31:0] mem [2048];
  logic        bram_ack_q = 1'b0;
  logic [31:0] bram_dat_q = 32'h0;

  always @(posedge clk) begin
    bram_ack_q <= sa.cyc & sa.stb & ~bram_ack_q;
    if (sa.cyc && sa.stb && !bram_ack_q) begin
      if (sa.we) begin
        for (int b = 0; b < 4; b++) begin
          if (sa.sel[b]) mem[sa.adr[12:2]][8*b +: 8] <= sa.dat_ms[8*b +: 8];
        end
      end
      bram_dat_q <= mem[sa.adr[12:2]];
    end
  end

  assign sa.ack    = bram_ack_q;
  assign sa.dat_sm = bram_dat_q;
  assign sa.err    = 1'b0;
  assign sa.rty    = 1'b0;

  // Trivial slave for the fixed-priority build: acks whatever it sees
  assign sb.ack    = sb.cyc & sb.stb;
  assign sb.dat_sm = 32'h0;
  assign sb.err    = 1'b0;
  assign sb.rty    = 1'b0;

  // Ack counters per master of the round-robin build
  int ack_cnt0 = 0;
  int ack_cnt1 = 0;
  always @(negedge clk) begin
    if (m0a.ack === 1'b1) ack_cnt0 <= ack_cnt0 + 1;
    if (m1a.ack === 1'b1) ack_cnt1 <= ack_cnt1 + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Owner visible on a slave port: 0 none, 1 master 0, 2 master 1
  function automatic logic [31:0] gnt_a();
    if (sa.cyc !== 1'b1) return 0;
    if (sa.adr == 32'h100) return 1;
    if (sa.adr == 32'h200) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] gnt_b();
    if (sb.cyc !== 1'b1) return 0;
    if (sb.adr == 32'h100) return 1;
    if (sb.adr == 32'h200) return 2;
    return 3;
  endfunction

  // Single transfer from master m; called just after a rising edge
  task automatic wb_xfer(input int m, input logic we, input logic [31:0] adr,
                         input logic [31:0] wdat, input logic keep_cyc,
                         output logic [31:0] rdat, output logic ok);
    ok = 1'b0;
    rdat = 32'h0;
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
    m_adr[m] = adr;  m_dat[m] = wdat; m_sel[m] = 4'hF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_ack[m] === 1'b1) begin
        ok = 1'b1;
        rdat = m_rdat[m];
        break;
      end
    end
    @(posedge clk); #1;
    m_stb[m] = 1'b0; m_we[m] = 1'b0;
    if (!keep_cyc) m_cyc[m] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        c0;
    logic        s0;
    logic        c1;
    logic        s1;
    int          n;
    logic [31:0] ga;
    logic [31:0] gb;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        ok;
    logic        got;
    logic [31:0] gdat;
    int          base0, base1;

    //            c0 s0 c1 s1  n  rr  fp
    vecs[0]  = '{1, 0, 1, 0, 8, 1, 1};
    vecs[1]  = '{0, 0, 1, 0, 1, 0, 0};
    vecs[2]  = '{1, 0, 1, 0, 8, 2, 1};
    vecs[3]  = '{1, 0, 0, 0, 1, 0, 1};
    vecs[4]  = '{1, 0, 1, 0, 8, 1, 1};
    vecs[5]  = '{0, 0, 1, 0, 1, 0, 0};
    vecs[6]  = '{1, 0, 1, 0, 8, 2, 1};
    vecs[7]  = '{0, 0, 0, 0, 2, 0, 0};
    vecs[8]  = '{0, 0, 1, 0, 3, 2, 2};
    vecs[9]  = '{1, 0, 1, 0, 2, 2, 2};
    vecs[10] = '{1, 0, 0, 0, 1, 0, 0};
    vecs[11] = '{1, 0, 0, 0, 2, 1, 1};
    vecs[12] = '{0, 0, 0, 0, 1, 0, 0};
    vecs[13] = '{0, 1, 0, 1, 2, 0, 0};

    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
      m_sel[m] = 4'h0; m_dat[m] = 32'h0;
    end
    m_adr[0] = 32'h100;
    m_adr[1] = 32'h200;

    // Reset holds the bus quiet even with both masters requesting
    idle(3);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    @(negedge clk);
    chk("rst_wbs_cyc", sa.cyc, 0);
    chk("rst_wbs_stb", sa.stb, 0);
    chk("rst_ack0", m0a.ack, 0);
    chk("rst_ack1", m1a.ack, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_still_idle", gnt_a(), 0);
    @(negedge clk);
    chk("first_gnt_m0", gnt_a(), 1);

    // Handoff: m0 drops at edge k, guard cycle, m1 owns from edge k+2
    idle(2);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("guard_idle", gnt_a(), 0);
    @(negedge clk);
    chk("handoff_m1", gnt_a(), 2);
    @(posedge clk); #1;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    idle(2);

    // Single master write then read through the block RAM
    base1 = ack_cnt1;
    wb_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd, ok);
    chk("wr_ack", ok, 1);
    wb_xfer(0, 1'b0, 32'h10, 32'h0, 1'b0, rd, ok);
    chk("rd_ack", ok, 1);
    chk("rd_data", rd, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      wb_xfer(0, 1'b1, 32'(i * 4), 32'h1111_0000 + 32'(i), 1'b0, rd, ok);
      chk("preload_ack", ok, 1);
    end
    idle(2);
    chk("m1_no_ack", 32'(ack_cnt1 - base1), 0);

    // Grant lock: m1 keeps cyc over four reads while m0 waits
    m_cyc[1] = 1'b1;
    idle(1);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0;
    m_adr[0] = 32'h10; m_sel[0] = 4'hF;
    base0 = ack_cnt0;
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1, 1'b0, 32'(i * 4), 32'h0, 1'b1, rd, ok);
      chk("lock_rd_ack", ok, 1);
      chk("lock_rd_data", rd, 32'h1111_0000 + 32'(i));
    end
    idle(1);
    chk("lock_m0_no_ack", 32'(ack_cnt0 - base0), 0);
    m_cyc[1] = 1'b0;
    got = 1'b0;
    gdat = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m0a.ack === 1'b1) begin
        got = 1'b1;
        gdat = m0a.dat_sm;
        break;
      end
    end
    chk("after_lock_m0_ack", got, 1);
    chk("after_lock_m0_data", gdat, 32'hDEADBEEF);
    @(posedge clk); #1;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    idle(2);

    // Reset in the cycle after m1's read strobe reaches the slave
    base0 = ack_cnt0;
    base1 = ack_cnt1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0;
    m_adr[1] = 32'h8; m_sel[1] = 4'hF;
    idle(1);
    chk("mid_read_granted", sa.cyc, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_cyc_immediate", sa.cyc, 0);
    @(negedge clk);
    chk("rst_hold_cyc", sa.cyc, 0);
    chk("rst_hold_ack1", m1a.ack, 0);
    @(posedge clk); #1;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    rst = 1'b0;
    idle(2);
    chk("abort_no_ack0", 32'(ack_cnt0 - base0), 0);
    chk("abort_no_ack1", 32'(ack_cnt1 - base1), 0);
    wb_xfer(0, 1'b0, 32'h4, 32'h0, 1'b0, rd, ok);
    chk("post_rst_rd_ack", ok, 1);
    chk("post_rst_rd_data", rd, 32'h1111_0001);
    idle(2);

    // Arbitration table on both builds from a fresh reset
    rst = 1'b1;
    m_adr[0] = 32'h100;
    m_adr[1] = 32'h200;
    idle(2);
    rst = 1'b0;
    for (int v = 0; v < 14; v++) begin
      for (int c = 0; c < vecs[v].n; c++) begin
        m_cyc[0] = vecs[v].c0; m_stb[0] = vecs[v].s0;
        m_cyc[1] = vecs[v].c1; m_stb[1] = vecs[v].s1;
        @(posedge clk); #1;
        chk($sformatf("rr_row%0d_cyc%0d", v, c), gnt_a(), vecs[v].ga);
        chk($sformatf("fp_row%0d_cyc%0d", v, c), gnt_b(), vecs[v].gb);
      end
    end
    chk("stray_stb_no_wbs_stb", sa.stb, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
